// File: rtl/scroll_tick_pkg.sv
// Shared constants and helpers for the scroll/animation tick generator.
package scroll_tick_pkg;

    localparam int unsigned BASE_DIV_DEF   = 32'd50000;
    localparam int unsigned DEF_PERIOD_DEF = 32'd67;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned ch_sel_w(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: active/shadow period, base-tick counter, pulse and square wave.
module tick_channel #(
    parameter int unsigned CH_W       = 9,
    parameter int unsigned DEF_PERIOD = 67
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            sync_clr,
    input  logic            tick,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_period,
    output logic            pend,
    output logic            pulse,
    output logic            sq
);

    localparam logic [CH_W-1:0] ZERO  = {CH_W{1'b0}};
    localparam logic [CH_W-1:0] ONE   = CH_W'(1);
    localparam logic [CH_W-1:0] DEF_P = CH_W'(DEF_PERIOD);

    logic [CH_W-1:0] period_r;
    logic [CH_W-1:0] shadow_r;
    logic [CH_W-1:0] cnt_r;
    logic            pend_r;
    logic            pulse_r;
    logic            sq_r;
    logic            idle_s;
    logic            wrap_s;

    // Period-0 idle detection and wrap on the last base tick of the period.
    always_comb begin
        idle_s = (period_r == ZERO);
        wrap_s = 1'b0;
        if (tick && !idle_s) begin
            wrap_s = (cnt_r == (period_r - ONE));
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Counter, outputs and period update; new periods only land on a boundary.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_r <= DEF_P;
            shadow_r <= ZERO;
            cnt_r    <= ZERO;
            pend_r   <= 1'b0;
            pulse_r  <= 1'b0;
            sq_r     <= 1'b0;
        end else if (sync_clr) begin
            cnt_r   <= ZERO;
            pulse_r <= 1'b0;
            sq_r    <= 1'b0;
            pend_r  <= 1'b0;
            if (wr_en) begin
                period_r <= wr_period;
            end else if (pend_r) begin
                period_r <= shadow_r;
            end
        end else begin
            pulse_r <= wrap_s;
            if (wrap_s) begin
                cnt_r <= ZERO;
                sq_r  <= ~sq_r;
            end else if (tick && !idle_s) begin
                cnt_r <= cnt_r + ONE;
            end
            // An idle channel or a write landing on the wrap takes effect at once.
            if (wr_en) begin
                if (idle_s || wrap_s) begin
                    period_r <= wr_period;
                    pend_r   <= 1'b0;
                end else begin
                    shadow_r <= wr_period;
                    pend_r   <= 1'b1;
                end
            end else if (wrap_s && pend_r) begin
                period_r <= shadow_r;
                pend_r   <= 1'b0;
            end
        end
    end

    assign pend  = pend_r;
    assign pulse = pulse_r;
    assign sq    = sq_r;

endmodule

// File: rtl/scroll_tick_gen.sv
// Multi-channel tick generator: shared prescaler feeding NUM_CH programmable dividers.
module scroll_tick_gen
    import scroll_tick_pkg::*;
#(
    parameter int unsigned BASE_DIV   = BASE_DIV_DEF,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned CH_W       = 9,
    parameter int unsigned DEF_PERIOD = DEF_PERIOD_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          sync_clr_i,
    input  logic                          cfg_we_i,
    input  logic [ch_sel_w(NUM_CH)-1:0]   cfg_ch_i,
    input  logic [CH_W-1:0]               cfg_period_i,
    output logic [NUM_CH-1:0]             cfg_pend_o,
    output logic                          base_tick_o,
    output logic [NUM_CH-1:0]             ch_pulse_o,
    output logic [NUM_CH-1:0]             ch_sq_o
);

    localparam int unsigned   CH_SEL_W = ch_sel_w(NUM_CH);
    localparam int unsigned   BW       = $clog2(BASE_DIV);
    localparam logic [BW-1:0] BASE_MAX = BW'(BASE_DIV - 1);

    logic [BW-1:0] base_cnt_r;
    logic          base_tick_r;
    logic          tick_s;

    // Base tick for the channels, aligned with the registered base_tick_o.
    always_comb begin
        tick_s = 1'b0;
        if (en_i && !sync_clr_i) begin
            tick_s = (base_cnt_r == BASE_MAX);
        end else begin
            tick_s = 1'b0;
        end
    end

    // Prescaler; frozen while en_i is low, strobe suppressed on restart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_cnt_r  <= {BW{1'b0}};
            base_tick_r <= 1'b0;
        end else if (sync_clr_i) begin
            base_cnt_r  <= {BW{1'b0}};
            base_tick_r <= 1'b0;
        end else if (en_i) begin
            base_tick_r <= (base_cnt_r == BASE_MAX);
            if (base_cnt_r == BASE_MAX) begin
                base_cnt_r <= {BW{1'b0}};
            end else begin
                base_cnt_r <= base_cnt_r + BW'(1);
            end
        end else begin
            base_tick_r <= 1'b0;
        end
    end

    assign base_tick_o = base_tick_r;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic wr_en_s;

        // Out-of-range select values never match any channel.
        assign wr_en_s = cfg_we_i && (cfg_ch_i == CH_SEL_W'(c));

        tick_channel #(
            .CH_W       (CH_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .sync_clr  (sync_clr_i),
            .tick      (tick_s),
            .wr_en     (wr_en_s),
            .wr_period (cfg_period_i),
            .pend      (cfg_pend_o[c]),
            .pulse     (ch_pulse_o[c]),
            .sq        (ch_sq_o[c])
        );
    end

endmodule

// File: tb/tb_scroll_tick_gen.sv
// Scoreboard bench: tick-numbered reference model pushes expected outputs, monitor compares.
module tb_scroll_tick_gen;

    localparam int BD  = 4;
    localparam int NCH = 2;
    localparam int CW  = 4;
    localparam int DP  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic          we = 1'b0;
    logic [0:0]    ch = 1'b0;
    logic [CW-1:0] per = '0;
    logic [NCH-1:0] pend_o;
    logic           btick_o;
    logic [NCH-1:0] pulse_o;
    logic [NCH-1:0] sq_o;

    scroll_tick_gen #(
        .BASE_DIV   (BD),
        .NUM_CH     (NCH),
        .CH_W       (CW),
        .DEF_PERIOD (DP)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .sync_clr_i   (clr),
        .cfg_we_i     (we),
        .cfg_ch_i     (ch),
        .cfg_period_i (per),
        .cfg_pend_o   (pend_o),
        .base_tick_o  (btick_o),
        .ch_pulse_o   (pulse_o),
        .ch_sq_o      (sq_o)
    );

    always #5 clk = ~clk;

    // Reference model: enabled-cycle count, base-tick number, and the tick
    // number at which each channel is due to wrap next.
    int m_run;
    int m_tick;
    int m_p    [NCH];
    int m_s    [NCH];
    int m_next [NCH];
    bit m_pend [NCH];
    bit m_sq   [NCH];

    logic [6:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int mon_cyc = 0;

    function automatic logic [6:0] dut_word();
        return {pend_o[1], pend_o[0], sq_o[1], sq_o[0], pulse_o[1], pulse_o[0], btick_o};
    endfunction

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_tick = 0;
        for (int k = 0; k < NCH; k++) begin
            m_p[k]    = DP;
            m_s[k]    = 0;
            m_next[k] = DP;
            m_pend[k] = 1'b0;
            m_sq[k]   = 1'b0;
        end
    endtask

    function automatic bit wraps_next(input int k);
        return (((m_run + 1) % BD) == 0) && (m_p[k] != 0) && ((m_tick + 1) == m_next[k]);
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expected outputs.
    task automatic cyc(input bit e, input bit cl, input bit w, input int c, input int v);
        bit bt;
        bit wrap;
        bit pl [NCH];
        en  = e;
        clr = cl;
        we  = w;
        ch  = 1'(c);
        per = CW'(v);
        bt  = 1'b0;
        for (int k = 0; k < NCH; k++) pl[k] = 1'b0;
        if (cl) begin
            m_run  = 0;
            m_tick = 0;
            for (int k = 0; k < NCH; k++) begin
                if (w && c == k) m_p[k] = v;
                else if (m_pend[k]) m_p[k] = m_s[k];
                m_pend[k] = 1'b0;
                m_sq[k]   = 1'b0;
                m_next[k] = m_p[k];
            end
        end else begin
            if (e) begin
                m_run++;
                if ((m_run % BD) == 0) begin
                    bt = 1'b1;
                    m_tick++;
                end
            end
            for (int k = 0; k < NCH; k++) begin
                wrap  = bt && (m_p[k] != 0) && (m_tick == m_next[k]);
                pl[k] = wrap;
                if (wrap) m_sq[k] = !m_sq[k];
                if (w && c == k) begin
                    if (m_p[k] == 0 || wrap) begin
                        m_p[k]    = v;
                        m_pend[k] = 1'b0;
                        m_next[k] = m_tick + v;
                    end else begin
                        m_s[k]    = v;
                        m_pend[k] = 1'b1;
                    end
                end else if (wrap) begin
                    if (m_pend[k]) begin
                        m_p[k]    = m_s[k];
                        m_pend[k] = 1'b0;
                    end
                    m_next[k] = m_tick + m_p[k];
                end
            end
        end
        exp_q.push_back({m_pend[1], m_pend[0], m_sq[1], m_sq[0], pl[1], pl[0], bt});
        @(negedge clk);
    endtask

    // Monitor: after each active edge, compare DUT outputs with the queued expectation.
    initial begin
        logic [6:0] exp_w;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                mon_cyc++;
                checks++;
                if (dut_word() !== exp_w) begin
                    errors++;
                    $display("FAIL cycle%0d {pend,sq,pulse,tick} got=%b want=%b", mon_cyc, dut_word(), exp_w);
                end
            end
        end
    end

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_zero", dut_word(), 7'b0000000);
        en = 1'b0; clr = 1'b0; we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_hold_zero", dut_word(), 7'b0000000);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", dut_word(), 7'b0000000);
        rst_n = 1'b1;
        model_reset();

        // Free run from reset with default periods.
        repeat (40) cyc(1, 0, 0, 0, 0);

        // Busy-channel write goes pending until the boundary.
        cyc(1, 0, 1, 1, 5);
        repeat (70) cyc(1, 0, 0, 0, 0);

        // Idle a channel, then restart it from idle.
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        repeat (30) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 2);
        repeat (20) cyc(1, 0, 0, 0, 0);

        // Enable held low for 10 cycles with a write inside the window.
        repeat (3) cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 7);
        repeat (5) cyc(0, 0, 0, 0, 0);

        // Write landing exactly on the channel's wrap cycle.
        n = 0;
        while (!wraps_next(0) && n < 200) begin
            cyc(1, 0, 0, 0, 0);
            n++;
        end
        cyc(1, 0, 1, 0, 4);
        repeat (60) cyc(1, 0, 0, 0, 0);

        // Randomised mix of enable gaps, restarts and writes.
        repeat (500) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 7) == 0), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 6)));
        end

        // Set up squares high with a pending write, then async reset.
        cyc(1, 0, 1, 0, 3);
        cyc(1, 0, 1, 1, 3);
        cyc(1, 1, 0, 0, 0);
        repeat (13) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 5);
        async_reset();
        repeat (40) cyc(1, 0, 0, 0, 0);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
